pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Program-counter / fetch sequencer that sits directly downstream of the 8-bit ALU.
//   Each cycle it consumes the ALU branch decision (jump) and decoded control, then produces the next
//   instruction-memory address.
//   Runs the processor start-to-halt and counts retired instructions and taken branches
//   for the test harness.
// PARAMETERS
//   PC_WIDTH   10  width of pc_out; instruction memory depth is 2**PC_WIDTH
//   OFF_WIDTH   8  width of signed relative branch offset (matches ALU reg_width)
//   CNT_WIDTH  16  width of instr_cnt and taken_cnt
// PORTS
//   clk         in   1          rising-edge clock
//   rst_n       in   1          asynchronous active-low reset
//   start       in   1          pulse: begin execution at PC 0 (ignored while RUN)
//   halt        in   1          decoded HALT instruction at current pc_out
//   stall       in   1          hold current instruction (e.g. multi-cycle LW)
//   br_en       in   1          current instruction is a conditional relative branch
//   jump        in   1          ALU branch condition (ALU op BEQ result)
//   br_off      in   OFF_WIDTH  signed relative offset, two's complement
//   abs_jmp     in   1          current instruction is an unconditional absolute jump
//   abs_target  in   PC_WIDTH   absolute jump destination
//   pc_out      out  PC_WIDTH   address of current instruction
//   running     out  1          1 in state RUN
//   done        out  1          1 in state HALTED
//   instr_cnt   out  CNT_WIDTH  retired-instruction count, saturating
//   taken_cnt   out  CNT_WIDTH  taken-branch/jump count, saturating
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc_out=0, running=0, done=0, instr_cnt=0,
//     taken_cnt=0. All outputs are registered; the reset value appears immediately,
//     not at the next edge.
//   FSM: IDLE -start-> RUN; RUN -halt&!stall-> HALTED; HALTED -start-> RUN. No other transitions.
//   start handling: on IDLE->RUN or HALTED->RUN, pc_out<=0, instr_cnt<=0, taken_cnt<=0
//     on the same edge.
//   In IDLE/HALTED: pc_out and counters hold. halt, stall, br_en, abs_jmp and jump are ignored.
//   RUN next-PC priority, evaluated per edge:
//     1 stall=1             -> pc holds, no counter change (halt is also deferred)
//     2 halt=1              -> pc holds, instr_cnt+1, go HALTED
//     3 abs_jmp=1           -> pc<=abs_target, instr_cnt+1, taken_cnt+1
//     4 br_en=1 & jump=1    -> pc<=pc+sext(br_off), instr_cnt+1, taken_cnt+1
//     5 otherwise           -> pc<=pc+1, instr_cnt+1 (not-taken branch counts as retired)
//   Arithmetic:
//     - br_off is sign-extended to PC_WIDTH.
//     - The sum is taken modulo 2**PC_WIDTH: forward wrap max->0, backward wrap 0-1 -> max.
//     - When OFF_WIDTH > PC_WIDTH, the offset is truncated to PC_WIDTH after sign-extension.
//   Counters:
//     - Saturate at 2**CNT_WIDTH-1 and never wrap.
//     - taken_cnt <= instr_cnt always.
//   Simultaneous events:
//     - abs_jmp with br_en&jump: the absolute jump wins; taken_cnt increments once.
//     - start together with halt in IDLE: the FSM goes to RUN and halt is ignored.
//   Latency: one cycle from decision inputs to the new pc_out; no combinational in->out paths.
//   Reset mid-RUN: immediate return to IDLE with all values cleared. No pending state survives.
// TESTING
//   1 Reset, start, 5 plain cycles -> pc_out 0,1,2,3,4,5; instr_cnt=5; taken_cnt=0; running=1.
//   2 pc=6, br_en=1, jump=1, br_off=8'hFC -> pc=2, taken_cnt+1.
//     Same with jump=0 -> pc=7, taken_cnt unchanged.
//   3 Wrap-around:
//     - pc=1023, plain cycle -> pc=0.
//     - pc=0, branch with br_off=-1 -> pc=1023.
//     - pc=1020, br_off=+10 -> pc=6.
//   4 Priority cases:
//     - stall=1 with halt=1 for 3 cycles -> pc and counters frozen, still RUN.
//     - stall drops -> HALTED, done=1, instr_cnt+1.
//     - abs_jmp=1 (target 0x155) with br_en&jump -> pc=0x155, taken_cnt+1 once.
//   5 rst_n low mid-RUN at pc=0x3A, asynchronous to clk -> outputs zero before next edge, state IDLE.
//     start after release -> pc=0.
//   6 Counter saturation: CNT_WIDTH=4, 20 plain cycles -> instr_cnt holds at 15.
//     start from HALTED -> counters clear to 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter / fetch sequencer with retired and taken-branch counters
module pc_sequencer #(
    parameter int PC_WIDTH  = 10,
    parameter int OFF_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 stall,
    input  logic                 br_en,
    input  logic                 jump,
    input  logic [OFF_WIDTH-1:0] br_off,
    input  logic                 abs_jmp,
    input  logic [PC_WIDTH-1:0]  abs_target,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic                 running,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] instr_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t               r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]  r_pc, w_pc_nxt;
    logic [CNT_WIDTH-1:0] r_instr_cnt, w_instr_nxt;
    logic [CNT_WIDTH-1:0] r_taken_cnt, w_taken_nxt;
    logic                 r_running, r_done;
    logic [PC_WIDTH-1:0]  w_off_ext;
    logic                 w_retire, w_taken;

    // Offset is sign-extended, or truncated when wider than the PC.
    generate
        if (OFF_WIDTH >= PC_WIDTH) begin : g_off_trunc
            assign w_off_ext = br_off[PC_WIDTH-1:0];
        end else begin : g_off_sext
            assign w_off_ext = {{(PC_WIDTH-OFF_WIDTH){br_off[OFF_WIDTH-1]}}, br_off};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_retire    = 1'b0;
        w_taken     = 1'b0;
        w_instr_nxt = r_instr_cnt;
        w_taken_nxt = r_taken_cnt;
        case (r_state)
            S_RUN: begin
                if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (halt) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_HALTED;
                end else if (abs_jmp) begin
                    w_pc_nxt = abs_target;
                    w_retire = 1'b1;
                    w_taken  = 1'b1;
                end else if (br_en && jump) begin
                    w_pc_nxt = r_pc + w_off_ext;
                    w_retire = 1'b1;
                    w_taken  = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + PC_ONE;
                    w_retire = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                end
            end
        endcase
        // Both counters saturate; taken only moves with retire, so taken never exceeds retired.
        if (r_state != S_RUN && start) begin
            w_instr_nxt = '0;
            w_taken_nxt = '0;
        end else begin
            if (w_retire && r_instr_cnt != '1) w_instr_nxt = r_instr_cnt + CNT_ONE;
            if (w_taken && r_taken_cnt != '1) w_taken_nxt = r_taken_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_instr_cnt <= '0;
            r_taken_cnt <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_instr_cnt <= w_instr_nxt;
            r_taken_cnt <= w_taken_nxt;
            r_running   <= (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_HALTED);
        end
    end

    assign pc_out    = r_pc;
    assign running   = r_running;
    assign done      = r_done;
    assign instr_cnt = r_instr_cnt;
    assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer (16-bit and 4-bit counter instances)
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt, stall, br_en, jump, abs_jmp;
    logic [7:0] br_off;
    logic [9:0] abs_target;

    logic [9:0]  pc, pc4;
    logic        running, done, running4, done4;
    logic [15:0] ic, tc;
    logic [3:0]  ic4, tc4;

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode;
    int m_pc, m_ic, m_tc;

    typedef struct {
        bit         st, hl, sl, be, jp, aj;
        logic [7:0] off;
        logic [9:0] tgt;
        int         pc, ic, tc;
        bit         run, dn;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    pc_sequencer #(.PC_WIDTH(10), .OFF_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .br_en(br_en), .jump(jump), .br_off(br_off), .abs_jmp(abs_jmp),
        .abs_target(abs_target), .pc_out(pc), .running(running), .done(done),
        .instr_cnt(ic), .taken_cnt(tc)
    );

    pc_sequencer #(.PC_WIDTH(10), .OFF_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .br_en(br_en), .jump(jump), .br_off(br_off), .abs_jmp(abs_jmp),
        .abs_target(abs_target), .pc_out(pc4), .running(running4), .done(done4),
        .instr_cnt(ic4), .taken_cnt(tc4)
    );

    function automatic int sat(int x, int w);
        int lim = (1 << w) - 1;
        return (x > lim) ? lim : x;
    endfunction

    function automatic vec_t v(bit st, bit hl, bit sl, bit be, bit jp, bit aj,
                               logic [7:0] off, logic [9:0] tgt,
                               int epc, int eic, int etc, bit erun, bit edn);
        vec_t r;
        r.st = st; r.hl = hl; r.sl = sl; r.be = be; r.jp = jp; r.aj = aj;
        r.off = off; r.tgt = tgt;
        r.pc = epc; r.ic = eic; r.tc = etc; r.run = erun; r.dn = edn;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: mode 0 idle, 1 run, 2 halted; counts kept unbounded and clipped on compare.
    task automatic model_edge();
        int o;
        if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_pc = 0; m_ic = 0; m_tc = 0;
            end
        end else if (!stall) begin
            m_ic++;
            if (halt) begin
                m_mode = 2;
            end else if (abs_jmp) begin
                m_pc = int'(abs_target); m_tc++;
            end else if (br_en && jump) begin
                o = $signed(br_off);
                m_pc = (((m_pc + o) % 1024) + 1024) % 1024;
                m_tc++;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_ic = 0; m_tc = 0;
    endtask

    task automatic step(bit st, bit hl, bit sl, bit be, bit jp, bit aj,
                        logic [7:0] off, logic [9:0] tgt);
        start = st; halt = hl; stall = sl; br_en = be; jump = jp; abs_jmp = aj;
        br_off = off; abs_target = tgt;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".pc"},      int'(pc),       m_pc);
        chk({tag, ".running"}, int'(running),  int'(m_mode == 1));
        chk({tag, ".done"},    int'(done),     int'(m_mode == 2));
        chk({tag, ".instr"},   int'(ic),       sat(m_ic, 16));
        chk({tag, ".taken"},   int'(tc),       sat(m_tc, 16));
        chk({tag, ".pc4"},     int'(pc4),      m_pc);
        chk({tag, ".instr4"},  int'(ic4),      sat(m_ic, 4));
        chk({tag, ".taken4"},  int'(tc4),      sat(m_tc, 4));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; halt = 0; stall = 0; br_en = 0; jump = 0; abs_jmp = 0;
        br_off = '0; abs_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.pc", int'(pc), 0);
        chk("reset.running", int'(running), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.instr", int'(ic), 0);
        chk("reset.taken", int'(tc), 0);
        rst_n = 1'b1;

        // Directed table: start, plain flow, branches, priority and HALTED behaviour.
        tbl.push_back(v(0,1,0,1,1,1, 8'h04, 10'h055,   0, 0, 0, 0, 0));
        tbl.push_back(v(1,1,0,0,0,0, 8'h00, 10'h000,   0, 0, 0, 1, 0));
        for (int i = 1; i <= 6; i++)
            tbl.push_back(v(0,0,0,0,0,0, 8'h00, 10'h000, i, i, 0, 1, 0));
        tbl.push_back(v(0,0,0,1,1,0, 8'hFC, 10'h000,   2, 7, 1, 1, 0));
        tbl.push_back(v(0,0,0,0,0,1, 8'h00, 10'h006,   6, 8, 2, 1, 0));
        tbl.push_back(v(0,0,0,1,0,0, 8'hFC, 10'h000,   7, 9, 2, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,1,1,0,0,0, 8'h00, 10'h000, 7, 9, 2, 1, 0));
        tbl.push_back(v(0,1,0,0,0,0, 8'h00, 10'h000,   7, 10, 2, 0, 1));
        tbl.push_back(v(0,1,1,1,1,1, 8'h04, 10'h0AA,   7, 10, 2, 0, 1));
        tbl.push_back(v(1,1,0,0,0,0, 8'h00, 10'h000,   0, 0, 0, 1, 0));
        tbl.push_back(v(0,0,0,1,1,1, 8'h04, 10'h155,   10'h155, 1, 1, 1, 0));
        tbl.push_back(v(1,0,0,0,0,0, 8'h00, 10'h000,   10'h156, 2, 1, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].hl, tbl[i].sl, tbl[i].be, tbl[i].jp, tbl[i].aj,
                 tbl[i].off, tbl[i].tgt);
            chk($sformatf("vec%0d.pc", i),      int'(pc),      tbl[i].pc);
            chk($sformatf("vec%0d.instr", i),   int'(ic),      tbl[i].ic);
            chk($sformatf("vec%0d.taken", i),   int'(tc),      tbl[i].tc);
            chk($sformatf("vec%0d.running", i), int'(running), int'(tbl[i].run));
            chk($sformatf("vec%0d.done", i),    int'(done),    int'(tbl[i].dn));
        end

        // Wrap-around in both directions.
        step(0,0,0,0,0,1, 8'h00, 10'd1023);
        chk("wrap.at_max", int'(pc), 1023);
        step(0,0,0,0,0,0, 8'h00, 10'd0);
        chk("wrap.fwd", int'(pc), 0);
        step(0,0,0,1,1,0, 8'hFF, 10'd0);
        chk("wrap.back", int'(pc), 1023);
        step(0,0,0,0,0,1, 8'h00, 10'd1020);
        step(0,0,0,1,1,0, 8'd10, 10'd0);
        chk("wrap.plus10", int'(pc), 6);
        check_model("wrap");

        // Asynchronous reset in the middle of a cycle.
        step(0,0,0,0,0,1, 8'h00, 10'h03A);
        chk("prerst.pc", int'(pc), 10'h03A);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.pc", int'(pc), 0);
        chk("arst.running", int'(running), 0);
        chk("arst.instr", int'(ic), 0);
        chk("arst.taken", int'(tc), 0);
        #2 rst_n = 1'b1;
        step(0,0,0,0,0,0, 8'h00, 10'd0);
        chk("postrst.idle", int'(running), 0);
        step(1,0,0,0,0,0, 8'h00, 10'd0);
        chk("postrst.start_pc", int'(pc), 0);
        check_model("postrst");

        // Saturation of the 4-bit counters, then clearing from HALTED.
        for (int i = 0; i < 20; i++) step(0,0,0,0,0,(i >= 10), 8'h00, 10'd5);
        chk("sat.instr4", int'(ic4), 15);
        chk("sat.taken4", int'(tc4), 10);
        chk("sat.instr16", int'(ic), 20);
        for (int i = 0; i < 10; i++) step(0,0,0,0,0,1, 8'h00, 10'd7);
        chk("sat.taken4_max", int'(tc4), 15);
        step(0,1,0,0,0,0, 8'h00, 10'd0);
        chk("sat.done4", int'(done4), 1);
        step(1,0,0,0,0,0, 8'h00, 10'd0);
        chk("sat.clear_instr4", int'(ic4), 0);
        chk("sat.clear_taken4", int'(tc4), 0);
        chk("sat.running4", int'(running4), 1);
        check_model("sat");

        // Randomised run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 4) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 5) == 0), 8'($urandom), 10'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
